// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the sodimm1 DDR3 Avalon-MM two-port arbiter.
package ddr3_arb_pkg;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    WR_BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              port;
    logic [SIZE_W-1:0] size;
  } arb_tag_t;

  // A burst length of 0 is treated as a single beat.
  function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] s);
    return (s == '0) ? SIZE_W'(1) : s;
  endfunction
endpackage

// File: rtl/simple_fifo_fwft.sv
// First-word-fall-through FIFO; head is valid combinationally whenever !empty.
module simple_fifo_fwft #(
  parameter int unsigned FIFO_PTR_DEPTH = 4,
  parameter int unsigned DATA_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);
  localparam int unsigned DEPTH = 1 << FIFO_PTR_DEPTH;
  localparam logic [FIFO_PTR_DEPTH:0] FULL_CNT = {1'b1, {FIFO_PTR_DEPTH{1'b0}}};

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [FIFO_PTR_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_PTR_DEPTH:0]   cnt_q;
  logic                      do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push while full is legal when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_PTR_DEPTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FIFO_PTR_DEPTH'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (FIFO_PTR_DEPTH + 1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (FIFO_PTR_DEPTH + 1)'(1);
    end
  end
endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Two-port burst arbiter onto the sodimm1 DDR3 Avalon-MM port with read-return steering.
// Optional macro DDR3_ARB_ROUND_ROBIN_EN selects round-robin instead of port-0 priority.
module ddr3_avl_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned TAG_PTR_DEPTH = 4
) (
  input  logic              sodimm1_ddr3_avl_clk,
  input  logic              sodimm1_ddr3_avl_reset_n,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SIZE_W-1:0] m0_size,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_wdata_ack,
  output logic              m0_rdata_valid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SIZE_W-1:0] m1_size,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_wdata_ack,
  output logic              m1_rdata_valid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              avl_ready,
  output logic              avl_burstbegin,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [SIZE_W-1:0] avl_size,
  output logic [DATA_W-1:0] avl_wdata,
  input  logic              avl_rdata_valid,
  input  logic [DATA_W-1:0] avl_rdata,
  output logic              err_spurious_rdata
);
  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [SIZE_W-1:0] remaining_q, remaining_d;
  logic [SIZE_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic [1:0]        elig, ready_v, ack_v, rv_v;
  logic              win, gnt_vld;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [SIZE_W-1:0] sel_size_n;
  logic [DATA_W-1:0] sel_wdata;
  logic              tag_push, tag_pop, tag_empty, tag_full;
  arb_tag_t          tag_in, tag_head;

  assign elig[0]    = m0_req && (m0_write || !tag_full);
  assign elig[1]    = m1_req && (m1_write || !tag_full);
  assign gnt_vld    = |elig;
  assign sel_write  = win ? m1_write : m0_write;
  assign sel_addr   = win ? m1_addr : m0_addr;
  assign sel_size_n = norm_size(win ? m1_size : m0_size);
  assign sel_wdata  = win ? m1_wdata : m0_wdata;

`ifdef DDR3_ARB_ROUND_ROBIN_EN
  logic rr_q;
  assign win = elig[rr_q] ? rr_q : ~rr_q;

  always_ff @(posedge sodimm1_ddr3_avl_clk or negedge sodimm1_ddr3_avl_reset_n) begin
    if (!sodimm1_ddr3_avl_reset_n)                        rr_q <= 1'b0;
    else if (state_q == IDLE && gnt_vld && avl_ready)     rr_q <= ~rr_q;
  end
`else
  assign win = ~elig[0];
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    remaining_d    = remaining_q;
    ready_v        = '0;
    ack_v          = '0;
    tag_push       = 1'b0;
    tag_in         = '0;
    avl_burstbegin = 1'b0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_addr       = '0;
    avl_size       = '0;
    avl_wdata      = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          avl_burstbegin = 1'b1;
          avl_addr       = sel_addr;
          avl_size       = sel_size_n;
          if (sel_write) begin
            avl_write_req = 1'b1;
            avl_wdata     = sel_wdata;
          end else begin
            avl_read_req = 1'b1;
          end
          if (avl_ready) begin
            ready_v[win] = 1'b1;
            if (sel_write) begin
              ack_v[win] = 1'b1;
              if (sel_size_n > SIZE_W'(1)) begin
                state_d     = WR_BURST;
                owner_d     = win;
                remaining_d = sel_size_n - SIZE_W'(1);
              end
            end else begin
              tag_push    = 1'b1;
              tag_in.port = win;
              tag_in.size = sel_size_n;
            end
          end
        end
      end
      WR_BURST: begin
        avl_write_req = 1'b1;
        avl_wdata     = owner_q ? m1_wdata : m0_wdata;
        if (avl_ready) begin
          ack_v[owner_q] = 1'b1;
          remaining_d    = remaining_q - SIZE_W'(1);
          if (remaining_q == SIZE_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return: the FIFO head names the owner of the beat in flight.
  always_comb begin
    rv_v    = '0;
    tag_pop = 1'b0;
    beat_d  = beat_q;
    err_d   = err_q;
    if (avl_rdata_valid) begin
      if (tag_empty) begin
        err_d = 1'b1;
      end else begin
        rv_v[tag_head.port] = 1'b1;
        if (beat_q + SIZE_W'(1) == tag_head.size) begin
          tag_pop = 1'b1;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + SIZE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sodimm1_ddr3_avl_clk or negedge sodimm1_ddr3_avl_reset_n) begin
    if (!sodimm1_ddr3_avl_reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      remaining_q <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  simple_fifo_fwft #(
    .FIFO_PTR_DEPTH (TAG_PTR_DEPTH),
    .DATA_WIDTH     ($bits(arb_tag_t))
  ) u_tag_fifo (
    .clk   (sodimm1_ddr3_avl_clk),
    .rst_n (sodimm1_ddr3_avl_reset_n),
    .push  (tag_push),
    .din   (tag_in),
    .pop   (tag_pop),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full)
  );

  assign m0_ready           = ready_v[0];
  assign m1_ready           = ready_v[1];
  assign m0_wdata_ack       = ack_v[0];
  assign m1_wdata_ack       = ack_v[1];
  assign m0_rdata_valid     = rv_v[0];
  assign m1_rdata_valid     = rv_v[1];
  assign m0_rdata           = avl_rdata;
  assign m1_rdata           = avl_rdata;
  assign err_spurious_rdata = err_q;
endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed self-checking bench for ddr3_avl_arbiter with a read-beat routing scoreboard.
module tb_ddr3_avl_arbiter;
  import ddr3_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m0_req, m0_write, m1_req, m1_write;
  logic [25:0]  m0_addr, m1_addr;
  logic [2:0]   m0_size, m1_size;
  logic [127:0] m0_wdata, m1_wdata;
  logic         m0_ready, m0_wdata_ack, m0_rdata_valid;
  logic         m1_ready, m1_wdata_ack, m1_rdata_valid;
  logic [127:0] m0_rdata, m1_rdata;
  logic         avl_ready, avl_burstbegin, avl_read_req, avl_write_req;
  logic [25:0]  avl_addr;
  logic [2:0]   avl_size;
  logic [127:0] avl_wdata, avl_rdata;
  logic         avl_rdata_valid, err_spurious_rdata;

  int checks = 0;
  int errors = 0;
  int acks;
  int exp_port;
  int sb_q[$];

  always #5 clk = ~clk;

  ddr3_avl_arbiter #(.TAG_PTR_DEPTH(4)) dut (
    .sodimm1_ddr3_avl_clk     (clk),
    .sodimm1_ddr3_avl_reset_n (rst_n),
    .m0_req (m0_req), .m0_write (m0_write), .m0_addr (m0_addr), .m0_size (m0_size),
    .m0_wdata (m0_wdata), .m0_ready (m0_ready), .m0_wdata_ack (m0_wdata_ack),
    .m0_rdata_valid (m0_rdata_valid), .m0_rdata (m0_rdata),
    .m1_req (m1_req), .m1_write (m1_write), .m1_addr (m1_addr), .m1_size (m1_size),
    .m1_wdata (m1_wdata), .m1_ready (m1_ready), .m1_wdata_ack (m1_wdata_ack),
    .m1_rdata_valid (m1_rdata_valid), .m1_rdata (m1_rdata),
    .avl_ready (avl_ready), .avl_burstbegin (avl_burstbegin),
    .avl_read_req (avl_read_req), .avl_write_req (avl_write_req),
    .avl_addr (avl_addr), .avl_size (avl_size), .avl_wdata (avl_wdata),
    .avl_rdata_valid (avl_rdata_valid), .avl_rdata (avl_rdata),
    .err_spurious_rdata (err_spurious_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pops the scoreboard whenever the controller model returns a beat.
  task automatic mon();
    int p;
    if (avl_rdata_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_rv0", m0_rdata_valid, 1'b0);
        chk("spurious_rv1", m1_rdata_valid, 1'b0);
      end else begin
        p = sb_q.pop_front();
        chk("route_rv0", m0_rdata_valid, p == 0);
        chk("route_rv1", m1_rdata_valid, p == 1);
        chk("rdata_bcast", (p == 1) ? m1_rdata : m0_rdata, avl_rdata);
      end
    end else if (m0_rdata_valid || m1_rdata_valid) begin
      chk("unexpected_rv", {m1_rdata_valid, m0_rdata_valid}, 2'b00);
    end
  endtask

  task automatic tick();
    mon();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_size = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_size = '0; m1_wdata = '0;
    avl_ready = 0; avl_rdata_valid = 0; avl_rdata = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {avl_burstbegin, avl_read_req, avl_write_req, m0_ready, m0_wdata_ack,
                        m0_rdata_valid, m1_ready, m1_wdata_ack, m1_rdata_valid,
                        err_spurious_rdata, avl_addr, avl_size}, '0);
    chk({tag, "_data"}, avl_wdata | m0_rdata | m1_rdata, '0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    sb_q.delete();
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_state", dut.state_q, IDLE);
    chk("reset_fifo_empty", dut.tag_empty, 1'b1);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Port 0 read, size 4 at 0x100.
    m0_req = 1; m0_write = 0; m0_addr = 26'h100; m0_size = 3'd4; avl_ready = 1;
    repeat (4) sb_q.push_back(0);
    #1;
    chk("t1_strobes", {avl_burstbegin, avl_read_req, avl_write_req}, 3'b110);
    chk("t1_addr", avl_addr, 26'h100);
    chk("t1_size", avl_size, 3'd4);
    chk("t1_m0_ready", m0_ready, 1'b1);
    chk("t1_m1_ready", m1_ready, 1'b0);
    tick();
    m0_req = 0; avl_ready = 0;
    for (int i = 0; i < 4; i++) begin
      avl_rdata_valid = 1; avl_rdata = 128'hA0 + 128'(i);
      #1; tick();
    end
    avl_rdata_valid = 0; avl_rdata = '0;
    #1;
    chk("t1_fifo_empty", dut.tag_empty, 1'b1);
    tick();

    // Port 1 write, size 3 at 0x20, ready pattern 1,0,1,1; port 0 request ignored meanwhile.
    acks = 0;
    m1_req = 1; m1_write = 1; m1_addr = 26'h20; m1_size = 3'd3; m1_wdata = 128'hB0; avl_ready = 1;
    #1;
    chk("t2_strobes", {avl_burstbegin, avl_read_req, avl_write_req}, 3'b101);
    chk("t2_addr", avl_addr, 26'h20);
    chk("t2_size", avl_size, 3'd3);
    chk("t2_wdata0", avl_wdata, 128'hB0);
    chk("t2_m1_ready", m1_ready, 1'b1);
    chk("t2_ack0", m1_wdata_ack, 1'b1);
    acks += int'(m1_wdata_ack);
    tick();
    m1_req = 0; m1_addr = '0; m1_size = '0; m1_wdata = 128'hB1;
    m0_req = 1; m0_write = 0; m0_addr = 26'h300; m0_size = 3'd1;
    for (int i = 0; i < 3; i++) begin
      avl_ready = (i != 0);
      #1;
      chk("t2_burstbegin", avl_burstbegin, 1'b0);
      chk("t2_wr_req", avl_write_req, 1'b1);
      chk("t2_rd_req", avl_read_req, 1'b0);
      chk("t2_m0_ignored", m0_ready, 1'b0);
      chk("t2_wdata", avl_wdata, m1_wdata);
      chk("t2_ack", m1_wdata_ack, avl_ready);
      acks += int'(m1_wdata_ack);
      tick();
      if (i != 0) m1_wdata = m1_wdata + 128'd1;
    end
    chk("t2_ack_count", acks, 3);
    avl_ready = 1;
    sb_q.push_back(0);
    #1;
    chk("t2_m0_granted_after", m0_ready, 1'b1);
    chk("t2_m0_read_req", avl_read_req, 1'b1);
    tick();
    m0_req = 0; avl_ready = 0; avl_rdata_valid = 1; avl_rdata = 128'hC0;
    #1; tick();
    avl_rdata_valid = 0;

    // Both ports request reads continuously.
    do_reset();
    m0_req = 1; m0_write = 0; m0_size = 3'd1; m0_addr = 26'h400;
    m1_req = 1; m1_write = 0; m1_size = 3'd1; m1_addr = 26'h500; avl_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef DDR3_ARB_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = 0;
`endif
      sb_q.push_back(exp_port);
      #1;
      chk("t3_m0_ready", m0_ready, exp_port == 0);
      chk("t3_m1_ready", m1_ready, exp_port == 1);
      chk("t3_addr", avl_addr, (exp_port == 1) ? 26'h500 : 26'h400);
      tick();
    end
    m0_req = 0; m1_req = 0; avl_ready = 0;
    for (int i = 0; i < 4; i++) begin
      avl_rdata_valid = 1; avl_rdata = 128'hD00 + 128'(i);
      #1; tick();
    end
    avl_rdata_valid = 0;

    // Fill the 16-entry tag FIFO; 17th read stalls, a write still passes.
    do_reset();
    m1_req = 1; m1_write = 0; m1_size = 3'd1; avl_ready = 1;
    for (int i = 0; i < 16; i++) begin
      m1_addr = 26'(i);
      sb_q.push_back(1);
      #1;
      chk("t4_read_accept", m1_ready, 1'b1);
      tick();
    end
    #1;
    chk("t4_full_ready", m1_ready, 1'b0);
    chk("t4_full_rd_req", avl_read_req, 1'b0);
    tick();
    m1_write = 1; m1_size = 3'd0; m1_wdata = 128'hE5;
    #1;
    chk("t4_write_ready", m1_ready, 1'b1);
    chk("t4_write_ack", m1_wdata_ack, 1'b1);
    chk("t4_write_req", avl_write_req, 1'b1);
    chk("t4_size0_norm", avl_size, 3'd1);
    tick();
    m1_req = 0; avl_ready = 0;
    #1;
    chk("t4_size0_single_beat", avl_write_req, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      avl_rdata_valid = 1; avl_rdata = 128'hF00 + 128'(i);
      #1; tick();
    end
    avl_rdata_valid = 0;

    // Interleaved returns: port 0 size 2, port 1 size 1 pushed on the pop cycle.
    m0_req = 1; m0_write = 0; m0_size = 3'd2; m0_addr = 26'h600; avl_ready = 1;
    sb_q.push_back(0); sb_q.push_back(0);
    #1;
    chk("t5_m0_ready", m0_ready, 1'b1);
    tick();
    m0_req = 0; avl_ready = 0; avl_rdata_valid = 1; avl_rdata = 128'hE0;
    #1; tick();
    avl_rdata = 128'hE1;
    m1_req = 1; m1_write = 0; m1_size = 3'd1; m1_addr = 26'h700; avl_ready = 1;
    sb_q.push_back(1);
    #1;
    chk("t5_m1_ready_push_pop", m1_ready, 1'b1);
    tick();
    m1_req = 0; avl_ready = 0; avl_rdata = 128'hE2;
    #1; tick();
    avl_rdata_valid = 0;
    #1;
    chk("t5_fifo_empty", dut.tag_empty, 1'b1);
    chk("t5_no_err", err_spurious_rdata, 1'b0);
    tick();

    // Spurious return with nothing outstanding.
    avl_rdata_valid = 1; avl_rdata = 128'h5A;
    #1; tick();
    avl_rdata_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_err_sticky", err_spurious_rdata, 1'b1);
      tick();
    end

    // Reset in the middle of a write burst with a read outstanding.
    do_reset();
    m0_req = 1; m0_write = 0; m0_size = 3'd2; m0_addr = 26'h800; avl_ready = 1;
    #1; tick();
    m0_req = 0;
    m1_req = 1; m1_write = 1; m1_size = 3'd5; m1_addr = 26'h900; m1_wdata = 128'h77;
    #1;
    chk("t7_write_accept", m1_wdata_ack, 1'b1);
    tick();
    m1_req = 0;
    #1;
    chk("t7_in_burst", avl_write_req, 1'b1);
    tick();
    #2;
    rst_n = 0;
    idle_inputs();
    sb_q.delete();
    #1;
    chk_idle("t7_async_reset");
    chk("t7_state_idle", dut.state_q, IDLE);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    chk_idle("t7_after_release");
    tick();
    avl_rdata_valid = 1; avl_rdata = 128'h99;
    #1; tick();
    avl_rdata_valid = 0;
    #1;
    chk("t7_stale_beat_spurious", err_spurious_rdata, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
